// File: rtl/register_file.sv
`default_nettype none
// =============================================================================
// Module  : register_file
// Brief   : 32x32 MIPS register file, r0 hardwired to zero, 2 async read ports,
//           1 sync write port with same-cycle write-to-read bypass.
// Revision: 1.0 - initial release
// =============================================================================
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  logic [c_DEPTH-1:0][DATA_WIDTH-1:0] w_words;
  logic                               w_bypass_en;

  assign w_words[0] = '0;

  // Each word is an independent enabled register; word 0 has no storage.
  for (genvar i = 1; i < c_DEPTH; i++) begin : g_word
    logic [DATA_WIDTH-1:0] r_word;

    always_ff @(posedge clock) begin
      if (!reset) begin
        r_word <= '0;
      end else if (write_enable && (write_addr == ADDR_WIDTH'(i))) begin
        r_word <= write_data;
      end
    end

    assign w_words[i] = r_word;
  end

  // Bypass is suppressed during reset since the pending write will be lost.
  assign w_bypass_en = write_enable && reset;

  always_comb begin
    read_data_a = w_words[read_addr_a];
    if (read_addr_a == '0) begin
      read_data_a = '0;
    end else if (w_bypass_en && (write_addr == read_addr_a)) begin
      read_data_a = write_data;
    end
  end

  always_comb begin
    read_data_b = w_words[read_addr_b];
    if (read_addr_b == '0) begin
      read_data_b = '0;
    end else if (w_bypass_en && (write_addr == read_addr_b)) begin
      read_data_b = write_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// =============================================================================
// Module  : tb_register_file
// Brief   : Directed vector bench for register_file.
// Revision: 1.0 - initial release
// =============================================================================
module tb_register_file;

  logic        clock;
  logic        reset;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr_a;
  logic [4:0]  read_addr_b;
  logic [31:0] read_data_a;
  logic [31:0] read_data_b;

  int checks_total;
  int checks_passed;

  register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .write_enable(write_enable),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .read_addr_a (read_addr_a),
    .read_addr_b (read_addr_b),
    .read_data_a (read_data_a),
    .read_data_b (read_data_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      checks_passed++;
  endtask

  // Inputs change just after the falling edge; outputs are checked 2 time
  // units later, well before the next rising edge commits anything.
  task automatic drive(input logic rst_n, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
    @(negedge clock);
    reset        = rst_n;
    write_enable = we;
    write_addr   = wa;
    write_data   = wd;
    read_addr_a  = ra;
    read_addr_b  = rb;
    #2;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset        = 1'b0;
    write_enable = 1'b0;
    write_addr   = '0;
    write_data   = '0;
    read_addr_a  = '0;
    read_addr_b  = '0;

    //            we    wa  wd             ra  rb  exp_a          exp_b
    vecs[0]  = '{1'b1,  5, 32'hDEADBEEF,   5,  0, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0,  0, 32'h0,          5,  5, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1,  0, 32'hFFFFFFFF,   0,  0, 32'h0,        32'h0};
    vecs[3]  = '{1'b0,  0, 32'h0,          0,  5, 32'h0,        32'hDEADBEEF};
    vecs[4]  = '{1'b1,  7, 32'h11111111,   7,  1, 32'h11111111, 32'h0};
    vecs[5]  = '{1'b1,  7, 32'h22222222,   7,  7, 32'h22222222, 32'h22222222};
    vecs[6]  = '{1'b0,  0, 32'h0,          7,  7, 32'h22222222, 32'h22222222};
    vecs[7]  = '{1'b1,  9, 32'hA5A5A5A5,   9, 31, 32'hA5A5A5A5, 32'h0};
    vecs[8]  = '{1'b0,  9, 32'h0,          9,  9, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[9]  = '{1'b0,  9, 32'h0,          9,  9, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[10] = '{1'b0,  9, 32'h0,          9,  9, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[11] = '{1'b1, 31, 32'hCAFEF00D,  31, 30, 32'hCAFEF00D, 32'h0};
    vecs[12] = '{1'b1, 30, 32'h00000001,  31, 30, 32'hCAFEF00D, 32'h00000001};

    // Reset for two edges, then check cleared state while still in reset.
    @(negedge clock);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
    check("reset_a_r0", read_data_a, 32'h0);
    check("reset_b_r5", read_data_b, 32'h0);

    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb);
      check($sformatf("vec%0d_a", i), read_data_a, vecs[i].ea);
      check($sformatf("vec%0d_b", i), read_data_b, vecs[i].eb);
    end

    // Reset clear: r5 holds DEADBEEF; during reset the stored value shows.
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
    check("rstclr_during_a", read_data_a, 32'hDEADBEEF);
    check("rstclr_during_b", read_data_b, 32'hA5A5A5A5);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
    check("rstclr_after_a", read_data_a, 32'h0);
    check("rstclr_after_b", read_data_b, 32'h0);

    // Write all registers on consecutive edges, then read back on both ports.
    for (int i = 1; i < 32; i++)
      drive(1'b1, 1'b1, 5'(i), 32'h1000_0000 + 32'(i), 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      check($sformatf("all_a_r%0d", i), read_data_a,
            (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i));
      check($sformatf("all_b_r%0d", 31 - i), read_data_b,
            (i == 31) ? 32'h0 : 32'h1000_0000 + 32'(31 - i));
    end

    // Reset vs write on the same edge: no bypass, write lost.
    drive(1'b0, 1'b1, 5'd3, 32'h12345678, 5'd3, 5'd31);
    check("rstwr_during_a", read_data_a, 32'h10000003);
    check("rstwr_during_b", read_data_b, 32'h1000001F);
    drive(1'b1, 1'b0, 5'd3, 32'h12345678, 5'd3, 5'd31);
    check("rstwr_after_a", read_data_a, 32'h0);
    check("rstwr_after_b", read_data_b, 32'h0);

    // Normal writes resume on the first edge after release.
    drive(1'b1, 1'b1, 5'd3, 32'h0BADC0DE, 5'd0, 5'd0);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    check("resume_a", read_data_a, 32'h0BADC0DE);
    check("resume_b", read_data_b, 32'h0BADC0DE);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
`default_nettype wire
